// File: rtl/iter_rotate_shift.sv
// Iterative rotate/shift unit: one bit position per clock, start/done handshake.
// Optional carry-out port enabled by defining ROTSHIFT_CARRY_EN.
module iter_rotate_shift #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] q,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             zero
`ifdef ROTSHIFT_CARRY_EN
  ,
  output logic             cout
`endif
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef enum logic [2:0] {
    OP_ROL = 3'b000,
    OP_ROR = 3'b001,
    OP_SHL = 3'b010,
    OP_SHR = 3'b011,
    OP_SAR = 3'b100
  } op_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nx;
  logic [AMT_W-1:0] count;
  logic [2:0]       op_q;
  logic             accept;
  logic             step;
  logic             finish;
  logic             out_bit;

  logic is_rol;
  logic is_ror;
  logic is_shl;
  logic is_shr;
  logic is_sar;

  assign is_rol = (op_q == OP_ROL);
  assign is_ror = (op_q == OP_ROR);
  assign is_shl = (op_q == OP_SHL);
  assign is_shr = (op_q == OP_SHR);
  assign is_sar = (op_q == OP_SAR);

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (count != '0) begin
          step = 1'b1;
        end else begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // One-position move of the work register and the bit it sheds
  always_comb begin
    work_nx = work;
    out_bit = 1'b0;
    unique case (1'b1)
      is_rol: begin
        work_nx = {work[WIDTH-2:0], work[WIDTH-1]};
        out_bit = work[WIDTH-1];
      end
      is_ror: begin
        work_nx = {work[0], work[WIDTH-1:1]};
        out_bit = work[0];
      end
      is_shl: begin
        work_nx = {work[WIDTH-2:0], 1'b0};
        out_bit = work[WIDTH-1];
      end
      is_shr: begin
        work_nx = {1'b0, work[WIDTH-1:1]};
        out_bit = work[0];
      end
      is_sar: begin
        work_nx = {work[WIDTH-1], work[WIDTH-1:1]};
        out_bit = work[0];
      end
      default: begin
        work_nx = work;
        out_bit = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      count <= '0;
      op_q  <= '0;
    end else if (accept) begin
      work  <= q;
      count <= amt;
      op_q  <= op;
    end else if (step) begin
      work  <= work_nx;
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r    <= '0;
      zero <= 1'b1;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        r    <= work;
        zero <= (work == '0);
      end
    end
  end

`ifdef ROTSHIFT_CARRY_EN
  logic carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
      cout  <= 1'b0;
    end else begin
      if (accept) begin
        carry <= 1'b0;
      end else if (step) begin
        carry <= out_bit;
      end
      if (finish) begin
        cout <= carry;
      end
    end
  end
`else
  logic unused_out_bit;
  assign unused_out_bit = out_bit;
`endif

endmodule

// File: tb/tb_iter_rotate_shift.sv
// Directed bench for iter_rotate_shift (WIDTH=8).
// Carry checks follow ROTSHIFT_CARRY_EN.
module tb_iter_rotate_shift;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [2:0] amt;
  logic [7:0] q;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] r;
  logic       zero;
`ifdef ROTSHIFT_CARRY_EN
  logic       cout;
`endif

  int n_run;
  int n_fail;

  iter_rotate_shift #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .amt   (amt),
    .q     (q),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .r     (r),
    .zero  (zero)
`ifdef ROTSHIFT_CARRY_EN
    ,
    .cout  (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o,
                       input logic [7:0] d,
                       input logic [2:0] a);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    q     = d;
    amt   = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'b010;
    q     = 8'h5A;
    amt   = 3'd6;
  endtask

  task automatic wait_done(output int lat, output int nb);
    lat = 0;
    nb  = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic count_done(input int cyc, output int nd);
    nd = 0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
  endtask

  int lat;
  int nb;
  int nd;

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = '0;
    amt    = '0;
    q      = '0;
    #12;
    check("rst_r", 32'(r), 32'h00);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ROL 0x81 by 1
    issue(3'b000, 8'h81, 3'd1);
    check("rol_busy", 32'(busy), 32'd1);
    wait_done(lat, nb);
    check("rol_lat", 32'(lat), 32'd2);
    check("rol_r", 32'(r), 32'h03);
    check("rol_zero", 32'(zero), 32'd0);
`ifdef ROTSHIFT_CARRY_EN
    check("rol_cout", 32'(cout), 32'd1);
`endif

    // SHR 0x80 by 7
    issue(3'b011, 8'h80, 3'd7);
    wait_done(lat, nb);
    check("shr_busy_cyc", 32'(nb), 32'd8);
    check("shr_r", 32'(r), 32'h01);
    @(posedge clk);
    #1;
    check("shr_done_fall", 32'(done), 32'd0);
    check("shr_r_hold", 32'(r), 32'h01);
`ifdef ROTSHIFT_CARRY_EN
    check("shr_cout", 32'(cout), 32'd0);
`endif

    // SAR then SHL by 0
    issue(3'b100, 8'h80, 3'd3);
    wait_done(lat, nb);
    check("sar_r", 32'(r), 32'hF0);
    issue(3'b010, 8'h01, 3'd0);
    wait_done(lat, nb);
    check("shl0_lat", 32'(lat), 32'd1);
    check("shl0_r", 32'(r), 32'h01);

    // SHL to zero, then start in the done cycle
    issue(3'b010, 8'h80, 3'd1);
    wait_done(lat, nb);
    check("shl_r", 32'(r), 32'h00);
    check("shl_zero", 32'(zero), 32'd1);
`ifdef ROTSHIFT_CARRY_EN
    check("shl_cout", 32'(cout), 32'd1);
`endif
    issue(3'b001, 8'h01, 3'd1);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat, nb);
    check("b2b_lat", 32'(lat), 32'd2);
    check("b2b_r", 32'(r), 32'h80);
    check("b2b_zero", 32'(zero), 32'd0);

    // start while busy must be ignored
    issue(3'b001, 8'h0F, 3'd4);
    @(negedge clk);
    start = 1'b1;
    op    = 3'b101;
    q     = 8'hFF;
    amt   = 3'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, nb);
    check("ign_lat", 32'(lat + 1), 32'd5);
    check("ign_r", 32'(r), 32'hF0);
`ifdef ROTSHIFT_CARRY_EN
    check("ign_cout", 32'(cout), 32'd1);
`endif
    count_done(10, nd);
    check("ign_one_done", 32'(nd), 32'd0);
    check("ign_ready", 32'(ready), 32'd1);

    // PASS keeps the operand
    issue(3'b110, 8'h5A, 3'd3);
    wait_done(lat, nb);
    check("pass_lat", 32'(lat), 32'd4);
    check("pass_r", 32'(r), 32'h5A);
`ifdef ROTSHIFT_CARRY_EN
    check("pass_cout", 32'(cout), 32'd0);
`endif

    // async reset mid-op
    issue(3'b000, 8'h01, 3'd5);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_r", 32'(r), 32'h00);
    check("arst_zero", 32'(zero), 32'd1);
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(10, nd);
    check("arst_no_done", 32'(nd), 32'd0);
    issue(3'b000, 8'h01, 3'd5);
    wait_done(lat, nb);
    check("post_lat", 32'(lat), 32'd6);
    check("post_r", 32'(r), 32'h20);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_rotate_shift.md
Name: iter_rotate_shift

Overview:
- Parametrised, multi-cycle successor to the fixed 4-bit rotate-left register.
- Rotates or shifts a WIDTH-bit operand, left or right, by a runtime amount.
- Moves one bit position per clock, driven by a small FSM with a start/done handshake.
- Sits in the ALU datapath beside the other opcode units; the result is registered and held for the ALU output mux.

Parameters:
- WIDTH, 8: operand/result width; power of two, >= 4.
- AMT_W, $clog2(WIDTH): width of the shift-amount port.

Ports:
- clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when ready=1.
- op  input  3  operation: 000 ROL, 001 ROR, 010 SHL, 011 SHR (logical), 100 SAR (arithmetic), 101-111 PASS.
- amt  input  AMT_W  shift/rotate distance, 0..WIDTH-1.
- q  input  WIDTH  operand.
- ready  output  1  high in IDLE.
- busy  output  1  high in BUSY.
- done  output  1  one-cycle pulse when r becomes valid.
- r  output  WIDTH  registered result; held until the next accept.
- zero  output  1  registered; 1 when r==0, updated together with r.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE.
  - r=0, zero=1, done=0, busy=0, ready=1, internal count=0, cout=0.
  - Any operation in flight is aborted with no done pulse.
- FSM states: IDLE, BUSY.
- IDLE:
  - start=1 accepts at that edge: work register <= q, count <= amt, op latched.
  - Next state is BUSY.
  - q, op and amt are not sampled again after the accepting edge.
- BUSY, count != 0:
  - Work register moves one position per the latched op; count decrements.
  - ROL: {w[W-2:0], w[W-1]}.
  - ROR: {w[0], w[W-1:1]}.
  - SHL: {w[W-2:0], 0}.
  - SHR: {0, w[W-1:1]}.
  - SAR: {w[W-1], w[W-1:1]}.
  - PASS: no change, but count still decrements.
- BUSY, count == 0:
  - r <= work register, zero <= (work==0), done <= 1 for this one edge.
  - Next state is IDLE.
- Latency: accept at edge k; done=1 and r valid in the cycle after edge k+amt+1.
  - amt=0 gives 1 BUSY cycle; amt=WIDTH-1 gives WIDTH BUSY cycles.
- done falls at the next edge. r and zero hold their value until the next completion.
- start while busy=1 is ignored: not queued, no error.
- start in the same cycle that done is high is accepted, since the state is IDLE by then. Back-to-back throughput is amt+2 cycles per op.
- Outputs are purely registered; there are no combinational paths from inputs to outputs.
- ready = (state==IDLE); busy = ~ready.

Optional Feature:
- Macro: ROTSHIFT_CARRY_EN.
- Defined:
  - Adds output port cout (1 bit).
  - A cout register records, on every BUSY step with count != 0:
    - the bit leaving the register, w[W-1] for left ops and w[0] for right ops;
    - for PASS, 0.
  - The cout register clears to 0 on accept.
  - The cout port is updated to that register's value on the same edge as r, so it holds the last bit moved out (0 for amt=0 or PASS).
  - Cleared by reset.
- Not defined: port cout and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8):
- ROL q=0x81, amt=1 -> done 2 edges after accept, r=0x03, zero=0; with carry enabled, cout=1.
- SHR q=0x80, amt=7 -> busy for 8 cycles, then r=0x01, done high for exactly 1 cycle; cout=0.
- SAR q=0x80, amt=3 -> r=0xF0. Then SHL q=0x01, amt=0 -> r=0x01, done 1 edge after accept.
- SHL q=0x80, amt=1 -> r=0x00, zero=1, cout=1. Then a second start in the done cycle (ROR q=0x01, amt=1) is accepted -> r=0x80.
- Accept ROR q=0x0F, amt=4; pulse start with q=0xFF, op=PASS during BUSY -> ignored; r=0xF0, only one done pulse.
- Accept ROL amt=5, assert Reset=0 mid-BUSY between clock edges -> immediately r=0, zero=1, ready=1, done=0. After release, no done appears, and a new op completes normally.
